hawk_ctrl_arb: RTL
==================

# hawk_ctrl_arb

Multi-channel successor to the Hawk control unit. It sits between N CPU request ports and the Hawk page read manager. It sequences table/list initialisation after reset, then arbitrates CPU translation requests round-robin and issues one ATT lookup at a time. It waits for either direct access or a table update, then returns a one-cycle grant with the translated PPA to the winning channel. A lookup/update timeout guards against a hung page manager.

## Interface
Parameters:
- NUM_CH, 4, number of CPU request channels (>=1)
- HPPA_W, 40, host physical page address width
- PPA_W, 40, translated physical page address width
- TIMEOUT_CYC, 1024, cycles allowed in LOOKUP or TBL_UPD before abort; 0 disables the timeout
- CH_W, max(1,$clog2(NUM_CH)), channel index width (derived)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- init_att_done  in  1  pulse: ATT initialisation complete
- init_list_done  in  1  pulse: list initialisation complete
- init_att  out  1  ATT init request, level
- init_list  out  1  list init request, level
- pgrd_mngr_ready  in  1  page manager can accept a lookup
- cpu_req_valid  in  NUM_CH  per-channel request, held until granted
- cpu_req_hppa  in  NUM_CH*HPPA_W  per-channel HPPA, channel i at [i*HPPA_W +: HPPA_W]
- lkup_req  out  1  lookup request, level
- lkup_hppa  out  HPPA_W  HPPA under lookup
- trnsl_allow_access  in  1  translation hit, PPA valid
- trnsl_tbl_update  in  1  translation needs table update, PPA valid
- trnsl_ppa  in  PPA_W  translated PPA
- tbl_update_done  in  1  pulse: table update complete
- cpu_grant  out  NUM_CH  one-hot grant pulse
- cpu_grant_ppa  out  PPA_W  PPA for the granted channel, valid while cpu_grant != 0
- lkup_timeout  out  1  one-cycle pulse on abort
- lkup_timeout_ch  out  CH_W  channel aborted, valid with lkup_timeout
- busy  out  1  high in any state other than ARB

## Operation
- States: INIT, ARB, LOOKUP, TBL_UPD, GRANT.
- INIT: init_att clears on init_att_done and init_list clears on init_list_done, independently and in any order, including in the same cycle. Go to ARB on the cycle both are cleared.
- ARB: needs pgrd_mngr_ready=1 and any cpu_req_valid bit set.
  - The winner is the first set bit at or after rr_ptr, scanning upward and wrapping at NUM_CH-1 to 0.
  - Latch the winner index and its HPPA, then go to LOOKUP.
- LOOKUP: lkup_req=1, lkup_hppa=latched HPPA.
  - trnsl_allow_access: latch trnsl_ppa, go to GRANT.
  - trnsl_tbl_update: latch trnsl_ppa, go to TBL_UPD.
  - If both are high in the same cycle, allow_access wins.
- TBL_UPD: lkup_req=0. On tbl_update_done go to GRANT with the PPA latched earlier.
- GRANT: cpu_grant[ch]=1 and cpu_grant_ppa=latched PPA for exactly one cycle. rr_ptr becomes ch+1, wrapping to 0 at NUM_CH. Next state is ARB.
- Timeout:
  - The counter clears on entry to LOOKUP and to TBL_UPD and increments each cycle spent there.
  - When it reaches TIMEOUT_CYC with no terminating event, pulse lkup_timeout with lkup_timeout_ch=ch and issue no grant. rr_ptr advances as for a grant. Next state is ARB.
  - A terminating event in the same cycle as expiry wins over the timeout.
- cpu_req_valid changes after a channel is latched are ignored until that transaction ends.
- Requesters drop valid the cycle after their grant.

## Timing
- Reset values:
  - state=INIT, init_att=1, init_list=1, rr_ptr=0
  - lkup_req=0, lkup_hppa=0, cpu_grant=0, cpu_grant_ppa=0
  - lkup_timeout=0, lkup_timeout_ch=0, busy=1
- All outputs are registered.
- Request at ARB in cycle t gives lkup_req=1 from t+1.
- allow_access sampled in cycle t+k gives lkup_req=0 and cpu_grant in t+k+1. ARB is in t+k+2.
- The TBL_UPD path grants the cycle after tbl_update_done is sampled.
- Minimum request-to-grant is 3 cycles (valid, lookup, allow_access the same cycle as lkup_req, grant). This gives one transaction per 3 cycles back-to-back.
- Reset asserted mid-transaction drops lkup_req and any grant asynchronously and returns to INIT. Re-initialisation is required.

## Test plan
- Reset release, init_list_done pulse in cycle 3, init_att_done in cycle 5 -> init_list=0 from cycle 4, init_att=0 from cycle 6, ARB in cycle 6, no lkup_req before it.
- NUM_CH=4, all valid, every lookup answered with allow_access one cycle after lkup_req -> grants in order ch0, ch1, ch2, ch3, ch0. cpu_grant_ppa matches trnsl_ppa each time.
- ch2 valid, hppa=0x123, trnsl_tbl_update with ppa=0x456, tbl_update_done 10 cycles later -> single cpu_grant=4'b0100 with ppa 0x456 the cycle after done.
- TIMEOUT_CYC=8, ch1 lookup with no response -> lkup_timeout pulse with ch=1 after 8 LOOKUP cycles, no grant, next request goes to ch2.
- allow_access and tbl_update high together -> GRANT path taken, TBL_UPD never entered.
- pgrd_mngr_ready=0 with valids pending -> lkup_req stays 0. Arbitration starts the cycle ready rises.

Source files
------------

// File: rtl/hawk_ctrl_arb.sv
`timescale 1ns/1ps
// Hawk control arbiter: sequences ATT/list init, then round-robins CPU translation
// requests into single ATT lookups and returns a one-cycle grant with the translated PPA.
module hawk_ctrl_arb #(
  parameter int NUM_CH      = 4,
  parameter int HPPA_W      = 40,
  parameter int PPA_W       = 40,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     init_att_done,
  input  logic                     init_list_done,
  output logic                     init_att,
  output logic                     init_list,
  input  logic                     pgrd_mngr_ready,
  input  logic [NUM_CH-1:0]        cpu_req_valid,
  input  logic [NUM_CH*HPPA_W-1:0] cpu_req_hppa,
  output logic                     lkup_req,
  output logic [HPPA_W-1:0]        lkup_hppa,
  input  logic                     trnsl_allow_access,
  input  logic                     trnsl_tbl_update,
  input  logic [PPA_W-1:0]         trnsl_ppa,
  input  logic                     tbl_update_done,
  output logic [NUM_CH-1:0]        cpu_grant,
  output logic [PPA_W-1:0]         cpu_grant_ppa,
  output logic                     lkup_timeout,
  output logic [CH_W-1:0]          lkup_timeout_ch,
  output logic                     busy
);

  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_INIT, S_ARB, S_LOOKUP, S_TBL_UPD, S_GRANT} state_t;

  state_t             r_state;
  logic               r_init_att;
  logic               r_init_list;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [CH_W-1:0]    r_ch;
  logic [PPA_W-1:0]   r_ppa;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_lkup_req;
  logic [HPPA_W-1:0]  r_lkup_hppa;
  logic [NUM_CH-1:0]  r_grant;
  logic [PPA_W-1:0]   r_grant_ppa;
  logic               r_timeout;
  logic [CH_W-1:0]    r_timeout_ch;
  logic               r_busy;

  logic [HPPA_W-1:0]  w_hppa_arr [NUM_CH];
  logic [NUM_CH-1:0]  w_ch_onehot;
  logic               w_win_found;
  logic [CH_W-1:0]    w_win_ch;
  logic [CH_W-1:0]    w_next_ptr;
  logic               w_expired;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_hppa_arr[gi]  = cpu_req_hppa[gi*HPPA_W +: HPPA_W];
    assign w_ch_onehot[gi] = (r_ch == CH_W'(gi));
  end

  // First requesting channel at or after r_rr_ptr, wrapping past the last channel.
  always_comb begin : p_pick
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    sum         = '0;
    idx         = '0;
    w_win_found = 1'b0;
    w_win_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      idx = sum[CH_W-1:0];
      if (!w_win_found && cpu_req_valid[idx]) begin
        w_win_found = 1'b1;
        w_win_ch    = idx;
      end
    end
  end

  assign w_next_ptr = (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
  assign w_expired  = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_INIT;
      r_init_att   <= 1'b1;
      r_init_list  <= 1'b1;
      r_rr_ptr     <= '0;
      r_ch         <= '0;
      r_ppa        <= '0;
      r_cnt        <= '0;
      r_lkup_req   <= 1'b0;
      r_lkup_hppa  <= '0;
      r_grant      <= '0;
      r_grant_ppa  <= '0;
      r_timeout    <= 1'b0;
      r_timeout_ch <= '0;
      r_busy       <= 1'b1;
    end else begin
      r_grant   <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (init_att_done)  r_init_att  <= 1'b0;
          if (init_list_done) r_init_list <= 1'b0;
          if ((!r_init_att || init_att_done) && (!r_init_list || init_list_done)) begin
            r_state <= S_ARB;
            r_busy  <= 1'b0;
          end
        end
        S_ARB: begin
          if (pgrd_mngr_ready && w_win_found) begin
            r_ch        <= w_win_ch;
            r_lkup_hppa <= w_hppa_arr[w_win_ch];
            r_lkup_req  <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (trnsl_allow_access) begin
            r_ppa       <= trnsl_ppa;
            r_lkup_req  <= 1'b0;
            r_grant     <= w_ch_onehot;
            r_grant_ppa <= trnsl_ppa;
            r_state     <= S_GRANT;
          end else if (trnsl_tbl_update) begin
            r_ppa      <= trnsl_ppa;
            r_lkup_req <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_TBL_UPD;
          end else if (w_expired) begin
            r_lkup_req   <= 1'b0;
            r_timeout    <= 1'b1;
            r_timeout_ch <= r_ch;
            r_rr_ptr     <= w_next_ptr;
            r_busy       <= 1'b0;
            r_state      <= S_ARB;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TBL_UPD: begin
          if (tbl_update_done) begin
            r_grant     <= w_ch_onehot;
            r_grant_ppa <= r_ppa;
            r_state     <= S_GRANT;
          end else if (w_expired) begin
            r_timeout    <= 1'b1;
            r_timeout_ch <= r_ch;
            r_rr_ptr     <= w_next_ptr;
            r_busy       <= 1'b0;
            r_state      <= S_ARB;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GRANT: begin
          r_grant_ppa <= '0;
          r_rr_ptr    <= w_next_ptr;
          r_busy      <= 1'b0;
          r_state     <= S_ARB;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign init_att        = r_init_att;
  assign init_list       = r_init_list;
  assign lkup_req        = r_lkup_req;
  assign lkup_hppa       = r_lkup_hppa;
  assign cpu_grant       = r_grant;
  assign cpu_grant_ppa   = r_grant_ppa;
  assign lkup_timeout    = r_timeout;
  assign lkup_timeout_ch = r_timeout_ch;
  assign busy            = r_busy;

endmodule
